// File: rtl/uart_cmd_rx_if.sv
// Bundle between the serial pin, the command receiver and the motor-control consumer.
// The receiver takes the master side: it reads the rx pin and drives the decoded command.
interface uart_cmd_rx_if;
   logic       uart_rx;
   logic [3:0] move_cmd;
   logic [3:0] speed_level;
   logic       valid;
   logic       frame_err;
   logic       pkt_err;

   modport master (
      input  uart_rx,
      output move_cmd,
      output speed_level,
      output valid,
      output frame_err,
      output pkt_err
   );

   modport slave (
      output uart_rx,
      input  move_cmd,
      input  speed_level,
      input  valid,
      input  frame_err,
      input  pkt_err
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver plus 3-byte packet decoder (header, command, checksum).
// Holds the last accepted move/speed command and strobes valid when it changes hands.
module uart_cmd_rx #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] HEADER       = 8'hA5,
   parameter int         TIMEOUT_CLKS = 50_000
) (
   input  logic          clk,
   input  logic          rst,
   uart_cmd_rx_if.master bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS);

   // byte FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // parser FSM states
   localparam logic [1:0] PS_WAIT_HDR = 2'd0;
   localparam logic [1:0] PS_WAIT_CMD = 2'd1;
   localparam logic [1:0] PS_WAIT_CHK = 2'd2;

   localparam logic [3:0] MOVE_STOP = 4'b1000;

   logic [1:0]       sync_reg;
   logic             rx_sync;

   logic [1:0]       byte_state_reg;
   logic [CNT_W-1:0] clk_cnt_reg;
   logic [2:0]       bit_cnt_reg;
   logic [7:0]       shift_reg;
   logic             byte_done_reg;
   logic             frame_err_reg;
   logic             break_wait_reg;

   logic [1:0]       parse_state_reg;
   logic [7:0]       cmd_byte_reg;
   logic [3:0]       move_cmd_reg;
   logic [3:0]       speed_level_reg;
   logic             valid_reg;
   logic             pkt_err_reg;

   logic [TO_W-1:0]  idle_cnt_reg;
   logic             timeout_hit;
   logic             chk_ok;

   assign rx_sync = sync_reg[1];

   // Two-flop synchroniser for the asynchronous rx pin; idles high so reset looks like a quiet line.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], bus.uart_rx};
      end
   end

   // Byte FSM: find the start edge, sample each bit at its middle, check the stop bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_state_reg <= ST_IDLE;
         clk_cnt_reg    <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         byte_done_reg  <= 1'b0;
         frame_err_reg  <= 1'b0;
         break_wait_reg <= 1'b0;
      end else begin
         byte_done_reg <= 1'b0;
         frame_err_reg <= 1'b0;
         case (byte_state_reg)
            ST_IDLE: begin
               clk_cnt_reg <= '0;
               // After a framing error the line may still be low; a low level then is not a start bit.
               if (break_wait_reg) begin
                  if (rx_sync) begin
                     break_wait_reg <= 1'b0;
                  end
               end else if (!rx_sync) begin
                  byte_state_reg <= ST_START;
                  bit_cnt_reg    <= '0;
               end
            end
            ST_START: begin
               if (clk_cnt_reg == HALF_LAST) begin
                  clk_cnt_reg    <= '0;
                  // A line back high at mid start bit was only a glitch.
                  byte_state_reg <= rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg <= '0;
                  shift_reg   <= {rx_sync, shift_reg[7:1]};
                  if (bit_cnt_reg == 3'd7) begin
                     bit_cnt_reg    <= '0;
                     byte_state_reg <= ST_STOP;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg    <= '0;
                  byte_state_reg <= ST_IDLE;
                  if (rx_sync) begin
                     byte_done_reg <= 1'b1;
                  end else begin
                     frame_err_reg  <= 1'b1;
                     break_wait_reg <= 1'b1;
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + 1'b1;
               end
            end
            default: begin
               byte_state_reg <= ST_IDLE;
               clk_cnt_reg    <= '0;
            end
         endcase
      end
   end

   // Inter-byte idle timer; only runs while a packet is partially received and the line is quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_reg <= '0;
      end else if (byte_done_reg || (byte_state_reg != ST_IDLE) ||
                   (parse_state_reg == PS_WAIT_HDR) || timeout_hit) begin
         idle_cnt_reg <= '0;
      end else begin
         idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
   end

   assign timeout_hit = (idle_cnt_reg == TO_LAST);

   // Checksum is header XOR command; move codes above STOP are undefined and rejected.
   assign chk_ok = (shift_reg == (HEADER ^ cmd_byte_reg)) && (cmd_byte_reg[3:0] <= MOVE_STOP);

   // Packet parser and output registers; a bad or stale packet never disturbs the held command.
   always_ff @(posedge clk) begin
      if (rst) begin
         parse_state_reg <= PS_WAIT_HDR;
         cmd_byte_reg    <= '0;
         move_cmd_reg    <= MOVE_STOP;
         speed_level_reg <= '0;
         valid_reg       <= 1'b0;
         pkt_err_reg     <= 1'b0;
      end else begin
         valid_reg   <= 1'b0;
         pkt_err_reg <= 1'b0;
         if (frame_err_reg) begin
            parse_state_reg <= PS_WAIT_HDR;
         end else if (byte_done_reg) begin
            case (parse_state_reg)
               PS_WAIT_HDR: begin
                  if (shift_reg == HEADER) begin
                     parse_state_reg <= PS_WAIT_CMD;
                  end
               end
               PS_WAIT_CMD: begin
                  cmd_byte_reg    <= shift_reg;
                  parse_state_reg <= PS_WAIT_CHK;
               end
               PS_WAIT_CHK: begin
                  parse_state_reg <= PS_WAIT_HDR;
                  if (chk_ok) begin
                     move_cmd_reg    <= cmd_byte_reg[3:0];
                     speed_level_reg <= cmd_byte_reg[7:4];
                     valid_reg       <= 1'b1;
                  end else begin
                     pkt_err_reg <= 1'b1;
                  end
               end
               default: parse_state_reg <= PS_WAIT_HDR;
            endcase
         end else if (timeout_hit) begin
            parse_state_reg <= PS_WAIT_HDR;
         end
      end
   end

   assign bus.move_cmd    = move_cmd_reg;
   assign bus.speed_level = speed_level_reg;
   assign bus.valid       = valid_reg;
   assign bus.frame_err   = frame_err_reg;
   assign bus.pkt_err     = pkt_err_reg;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial packets in, strobe counts and held command checked.
// Bit time and timeout are scaled down so the whole run stays short; ratios follow the link.
module tb_uart_cmd_rx;

   localparam int         CPB     = 100;
   localparam int         TIMEOUT = 5000;
   localparam logic [7:0] HDR     = 8'hA5;

   logic clk;
   logic rst;

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(
      .CLKS_PER_BIT (CPB),
      .HEADER       (HDR),
      .TIMEOUT_CLKS (TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   int valid_cnt = 0;
   int frame_cnt = 0;
   int pkt_cnt   = 0;
   int multi_cnt = 0;

   int v0, f0, p0;

   // Count strobe cycles away from the active edge.
   always @(negedge clk) begin
      if (bus.valid === 1'b1)     valid_cnt++;
      if (bus.frame_err === 1'b1) frame_cnt++;
      if (bus.pkt_err === 1'b1)   pkt_cnt++;
      if ((int'(bus.valid) + int'(bus.frame_err) + int'(bus.pkt_err)) > 1) multi_cnt++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      v0 = valid_cnt;
      f0 = frame_cnt;
      p0 = pkt_cnt;
   endtask

   task automatic drive_bit(input logic v);
      bus.uart_rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
      drive_bit(1'b1);
   endtask

   task automatic send_pkt(input logic [7:0] h, input logic [7:0] c, input logic [7:0] k);
      send_byte(h, 1'b1);
      send_byte(c, 1'b1);
      send_byte(k, 1'b1);
      repeat (20) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_outputs(input string tag, input int mv, input int sp);
      chk({tag, "_move"},  int'(bus.move_cmd),    mv);
      chk({tag, "_speed"}, int'(bus.speed_level), sp);
   endtask

   task automatic check_deltas(input string tag, input int dv, input int df, input int dp);
      chk({tag, "_valid_pulses"}, valid_cnt - v0, dv);
      chk({tag, "_frame_pulses"}, frame_cnt - f0, df);
      chk({tag, "_pkt_pulses"},   pkt_cnt - p0,   dp);
   endtask

   initial begin
      rst = 1'b1;
      bus.uart_rx = 1'b1;
      do_reset();

      // reset state
      check_outputs("reset", 4'b1000, 0);
      chk("reset_valid",     int'(bus.valid),     0);
      chk("reset_frame_err", int'(bus.frame_err), 0);
      chk("reset_pkt_err",   int'(bus.pkt_err),   0);
      $display("step reset: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // good packet: reverse, speed 1
      snap();
      send_pkt(8'hA5, 8'h13, 8'hB6);
      check_deltas("pkt_13", 1, 0, 0);
      check_outputs("pkt_13", 4'b0011, 1);
      $display("step A5 13 B6: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // bad checksum from reset: held values must stay at reset defaults
      do_reset();
      snap();
      send_pkt(8'hA5, 8'h25, 8'h81);
      check_deltas("badchk", 0, 0, 1);
      check_outputs("badchk", 4'b1000, 0);
      $display("step A5 25 81: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // correct checksum but illegal move code 1001
      snap();
      send_pkt(8'hA5, 8'h49, 8'hEC);
      check_deltas("illegal", 0, 0, 1);
      check_outputs("illegal", 4'b1000, 0);
      $display("step A5 49 EC: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // framing error on a stray byte, then a good packet
      snap();
      send_byte(8'h55, 1'b0);
      repeat (CPB) @(negedge clk);
      check_deltas("frame", 0, 1, 0);
      $display("step 55 with low stop bit: frame_err pulses=%0d", frame_cnt - f0);
      snap();
      send_pkt(8'hA5, 8'h72, 8'hD7);
      check_deltas("after_frame", 1, 0, 0);
      check_outputs("after_frame", 4'b0010, 7);
      $display("step A5 72 D7: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // partial packet abandoned by timeout, then a good packet
      snap();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h13, 1'b1);
      repeat (TIMEOUT + TIMEOUT / 5) @(negedge clk);
      send_pkt(8'hA5, 8'h30, 8'h95);
      check_deltas("timeout", 1, 0, 0);
      check_outputs("timeout", 4'b0000, 3);
      $display("step A5 13 <idle> A5 30 95: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // short low glitch well under half a bit time
      snap();
      bus.uart_rx = 1'b0;
      repeat (CPB / 5) @(negedge clk);
      bus.uart_rx = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      check_deltas("glitch", 0, 0, 0);
      check_outputs("glitch", 4'b0000, 3);
      $display("step glitch: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      // reset in the middle of the command byte's data bits
      send_byte(8'hA5, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      do_reset();
      check_outputs("midreset", 4'b1000, 0);
      chk("midreset_valid", int'(bus.valid), 0);
      snap();
      send_pkt(8'hA5, 8'h41, 8'hE4);
      check_deltas("post_reset", 1, 0, 0);
      check_outputs("post_reset", 4'b0001, 4);
      $display("step reset mid-byte then A5 41 E4: move=%0d speed=%0d", bus.move_cmd, bus.speed_level);

      chk("strobe_overlap", multi_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
